// File: rtl/uart_rx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl_pkg
// Brief    : Shared types and entry layout for the UART RX controller.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_SETTLE  = 2'd2
   } state_e;

   // FIFO entry is {framing, parity, byte}
   localparam int ENTRY_W     = 10;
   localparam int BYTE_LSB    = 0;
   localparam int BYTE_MSB    = 7;
   localparam int PARITY_BIT  = 8;
   localparam int FRAMING_BIT = 9;

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl_fifo
// Brief    : Synchronous FIFO with a registered head/valid output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl_fifo #(
   parameter int DEPTH   = 8,
   parameter int ENTRY_W = 10
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_en_i,
   input  logic [ENTRY_W-1:0]       wr_data_i,
   input  logic                     rd_en_i,
   output logic [ENTRY_W-1:0]       head_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     wr_accept_o,
   output logic                     drop_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [ENTRY_W-1:0] head_q, head_d;
   logic               valid_q;
   logic               rd_eff, full, wr_acc;

   assign rd_eff = rd_en_i && (count_q != '0);
   assign full   = (count_q == CNT_W'(DEPTH));
   // A pop in the same cycle frees a slot, so a full FIFO still accepts
   assign wr_acc = wr_en_i && (!full || rd_eff);

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
      rd_ptr_d = rd_ptr_q + PTR_W'(rd_eff);
      count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_eff);
      head_d   = '0;
      if (count_d != '0) begin
         head_d = (wr_acc && (wr_ptr_q == rd_ptr_d)) ? wr_data_i : mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= (count_d != '0);
      end
   end

   assign head_o      = head_q;
   assign valid_o     = valid_q;
   assign count_o     = count_q;
   assign wr_accept_o = wr_acc;
   assign drop_o      = wr_en_i && full && !rd_eff;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Brief    : Drains a UART receiver into a host FIFO with overflow, level and
//            character-timeout interrupts. UART_RX_CTRL_TIMEOUT_EN adds timeout.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
#(
   parameter int DEPTH         = 8,
   parameter int TIMEOUT_TICKS = 320
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     baud_clock_i,
   input  logic                     receive_full_i,
   input  logic [7:0]               rx_byte_i,
   input  logic                     parity_err_i,
   input  logic                     framing_error_i,
   output logic                     read_rx_byte_o,
   output logic                     clear_parity_o,
   output logic                     clear_framing_error_o,
   input  logic                     host_rd_i,
   output logic [ENTRY_W-1:0]       host_data_o,
   output logic                     host_valid_o,
   output logic [$clog2(DEPTH):0]   fifo_count_o,
   input  logic [$clog2(DEPTH):0]   irq_thresh_i,
   input  logic                     clr_ovf_i,
   output logic                     fifo_ovf_o,
   output logic                     timeout_o,
   output logic                     irq_o
);

   state_e             state_q;
   logic               read_q, clr_par_q, clr_frm_q;
   logic [ENTRY_W-1:0] entry_q;
   logic               fifo_ovf_q, irq_q;
   logic               wr_en, wr_accept, drop;

   // Outputs are registered, so they are set on entry to CAPTURE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         read_q    <= 1'b0;
         clr_par_q <= 1'b0;
         clr_frm_q <= 1'b0;
         entry_q   <= '0;
      end else begin
         read_q    <= 1'b0;
         clr_par_q <= 1'b0;
         clr_frm_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (receive_full_i) begin
                  state_q                     <= ST_CAPTURE;
                  read_q                      <= 1'b1;
                  clr_par_q                   <= parity_err_i;
                  clr_frm_q                   <= framing_error_i;
                  entry_q[BYTE_MSB:BYTE_LSB]  <= rx_byte_i;
                  entry_q[PARITY_BIT]         <= parity_err_i;
                  entry_q[FRAMING_BIT]        <= framing_error_i;
               end
            end
            ST_CAPTURE: state_q <= ST_SETTLE;
            ST_SETTLE:  state_q <= ST_IDLE;
            default:    state_q <= ST_IDLE;
         endcase
      end
   end

   assign wr_en = (state_q == ST_CAPTURE);

   uart_rx_ctrl_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W)
   ) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .wr_en_i     (wr_en),
      .wr_data_i   (entry_q),
      .rd_en_i     (host_rd_i),
      .head_o      (host_data_o),
      .valid_o     (host_valid_o),
      .count_o     (fifo_count_o),
      .wr_accept_o (wr_accept),
      .drop_o      (drop)
   );

   // A drop wins over a same-cycle clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fifo_ovf_q <= 1'b0;
      end else if (drop) begin
         fifo_ovf_q <= 1'b1;
      end else if (clr_ovf_i) begin
         fifo_ovf_q <= 1'b0;
      end
   end

`ifdef UART_RX_CTRL_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

   logic [TO_W-1:0] to_cnt_q;
   logic            timeout_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (wr_accept || host_rd_i || !host_valid_o) begin
            to_cnt_q <= '0;
         end else if (baud_clock_i && (to_cnt_q != TO_W'(TIMEOUT_TICKS))) begin
            to_cnt_q <= to_cnt_q + 1'b1;
         end
         if (host_rd_i || !host_valid_o) begin
            timeout_q <= 1'b0;
         end else if (to_cnt_q == TO_W'(TIMEOUT_TICKS)) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign timeout_o = timeout_q;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = baud_clock_i & wr_accept & (TIMEOUT_TICKS != 0);
   assign timeout_o    = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= fifo_ovf_q | timeout_o |
                  ((irq_thresh_i != '0) && (fifo_count_o >= irq_thresh_i));
      end
   end

   assign read_rx_byte_o        = read_q;
   assign clear_parity_o        = clr_par_q;
   assign clear_framing_error_o = clr_frm_q;
   assign fifo_ovf_o            = fifo_ovf_q;
   assign irq_o                 = irq_q;

endmodule
`default_nettype wire
